// File: rtl/fml_rr_arbiter.sv
// Two-master round-robin arbiter for the single FML port of the DDR interface.
// One grant per transaction, combinational ack/data return, one-cycle turnaround, watchdog.
module fml_rr_arbiter #(
    parameter int unsigned SDRAM_DEPTH = 26,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,

    input  logic [SDRAM_DEPTH-1:0] m0_adr,
    input  logic                   m0_stb,
    input  logic                   m0_we,
    input  logic [3:0]             m0_sel,
    input  logic [31:0]            m0_di,
    output logic                   m0_ack,
    output logic                   m0_err,

    input  logic [SDRAM_DEPTH-1:0] m1_adr,
    input  logic                   m1_stb,
    input  logic                   m1_we,
    input  logic [3:0]             m1_sel,
    input  logic [31:0]            m1_di,
    output logic                   m1_ack,
    output logic                   m1_err,

    output logic [31:0]            m_do,

    output logic [SDRAM_DEPTH-1:0] s_adr,
    output logic                   s_we,
    output logic [3:0]             s_sel,
    output logic [31:0]            s_do,
    output logic                   s_stb,
    input  logic                   s_ack,
    input  logic [31:0]            s_di,

    output logic [1:0]             grant
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StBusy0, StBusy1, StTurn} state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic busy;
    logic owner;
    logic timeout;
    logic done;

    always_comb begin
        busy    = (state_q == StBusy0) || (state_q == StBusy1);
        owner   = (state_q == StBusy1);
        // A real ack in the watchdog cycle wins over the forced termination.
        timeout = busy && (cnt_q == CntW'(TIMEOUT)) && !s_ack;
        done    = busy && (s_ack || timeout);
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                // On a tie the master not served last wins.
                if (m0_stb && (!m1_stb || last_q)) begin
                    state_d = StBusy0;
                end else if (m1_stb) begin
                    state_d = StBusy1;
                end
            end
            StBusy0, StBusy1: begin
                if (done) begin
                    last_d  = owner;
                    state_d = StTurn;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StTurn:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        s_adr  = '0;
        s_we   = 1'b0;
        s_sel  = '0;
        s_do   = '0;
        s_stb  = 1'b0;
        m_do   = '0;
        m0_ack = 1'b0;
        m0_err = 1'b0;
        m1_ack = 1'b0;
        m1_err = 1'b0;
        grant  = 2'b00;
        if (busy) begin
            if (owner) begin
                s_adr = m1_adr;
                s_we  = m1_we;
                s_sel = m1_sel;
                s_do  = m1_di;
                s_stb = m1_stb && !s_ack && !timeout;
                grant = 2'b10;
            end else begin
                s_adr = m0_adr;
                s_we  = m0_we;
                s_sel = m0_sel;
                s_do  = m0_di;
                s_stb = m0_stb && !s_ack && !timeout;
                grant = 2'b01;
            end
            m_do   = s_ack ? s_di : '0;
            m0_ack = !owner && done;
            m0_err = !owner && timeout;
            m1_ack = owner && done;
            m1_err = owner && timeout;
        end
    end

endmodule

// File: tb/tb_fml_rr_arbiter.sv
// Bench for fml_rr_arbiter: masters push expected requests into per-master queues, a monitor
// runs a cycle-level reference of the arbitration rules and checks every DUT output.
module tb_fml_rr_arbiter;

    localparam int unsigned AW = 26;
    localparam int unsigned TO = 8;

    typedef struct packed {
        logic [AW-1:0] adr;
        logic          we;
        logic [3:0]    sel;
        logic [31:0]   di;
    } txn_t;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic [AW-1:0] drv_adr [2];
    logic          drv_stb [2];
    logic          drv_we  [2];
    logic [3:0]    drv_sel [2];
    logic [31:0]   drv_di  [2];
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0]   m_do;
    logic [AW-1:0] s_adr;
    logic          s_we, s_stb, s_ack;
    logic [3:0]    s_sel;
    logic [31:0]   s_do, s_di;
    logic [1:0]    grant;

    txn_t q0[$];
    txn_t q1[$];
    int   glog[$];
    int   n_chk = 0;
    int   n_err = 0;

    bit          slave_en    = 1'b1;
    int          slave_delay = -1;
    bit          slave_fix   = 1'b0;
    logic [31:0] slave_data  = 32'h0;

    fml_rr_arbiter #(.SDRAM_DEPTH(AW), .TIMEOUT(TO)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .m0_adr(drv_adr[0]), .m0_stb(drv_stb[0]), .m0_we(drv_we[0]), .m0_sel(drv_sel[0]),
        .m0_di(drv_di[0]), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_adr(drv_adr[1]), .m1_stb(drv_stb[1]), .m1_we(drv_we[1]), .m1_sel(drv_sel[1]),
        .m1_di(drv_di[1]), .m1_ack(m1_ack), .m1_err(m1_err),
        .m_do(m_do),
        .s_adr(s_adr), .s_we(s_we), .s_sel(s_sel), .s_do(s_do), .s_stb(s_stb),
        .s_ack(s_ack), .s_di(s_di), .grant(grant)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string n);
        chk({n, "_ctl"}, 64'({m0_ack, m1_ack, m0_err, m1_err, s_stb, s_we, s_sel, grant}), 64'd0);
        chk({n, "_adr"}, 64'(s_adr), 64'd0);
        chk({n, "_data"}, {s_do, m_do}, 64'd0);
    endtask

    function automatic txn_t mk(input logic [AW-1:0] a, input logic w, input logic [3:0] s,
                                input logic [31:0] d);
        txn_t t;
        t.adr = a;
        t.we  = w;
        t.sel = s;
        t.di  = d;
        return t;
    endfunction

    function automatic txn_t rnd_txn();
        return mk(AW'($urandom), 1'($urandom), 4'($urandom), $urandom);
    endfunction

    task automatic req(input int m, input txn_t t);
        if (m == 0) q0.push_back(t);
        else q1.push_back(t);
        drv_adr[m] = t.adr;
        drv_we[m]  = t.we;
        drv_sel[m] = t.sel;
        drv_di[m]  = t.di;
        drv_stb[m] = 1'b1;
    endtask

    task automatic wait_done(input int m, output logic [31:0] rdata, output bit errf);
        bit got;
        got   = 1'b0;
        rdata = '0;
        errf  = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge sys_clk);
            if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) begin
                got   = 1'b1;
                rdata = m_do;
                errf  = (m == 0) ? m0_err : m1_err;
            end
        end
        chk("ack_seen", 64'(got), 64'd1);
        @(posedge sys_clk);
        #1;
        drv_stb[m] = 1'b0;
    endtask

    task automatic run_master(input int m, input int n, input int maxgap);
        logic [31:0] rd;
        bit          ef;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, maxgap) + 1) @(posedge sys_clk);
            #1;
            req(m, rnd_txn());
            wait_done(m, rd, ef);
        end
    endtask

    // Slave: acks a strobed request after a random (or forced) number of cycles.
    initial begin : slave
        bit stb_seen;
        int wait_n;
        wait_n = -1;
        s_ack  = 1'b0;
        s_di   = '0;
        forever begin
            @(negedge sys_clk);
            stb_seen = s_stb;
            @(posedge sys_clk);
            #1;
            if (!slave_en) begin
                wait_n = -1;
                continue;
            end
            s_ack = 1'b0;
            if (!sys_rst_n) wait_n = -1;
            else if (wait_n < 0 && stb_seen)
                wait_n = (slave_delay > 0) ? slave_delay - 1 : int'($urandom_range(0, 4));
            else if (wait_n > 0) wait_n--;
            if (wait_n == 0) begin
                s_ack  = 1'b1;
                s_di   = slave_fix ? slave_data : $urandom;
                wait_n = -1;
            end
        end
    end

    // Reference: owner/turnaround/last-served bookkeeping derived from the arbitration rules.
    initial begin : monitor
        int   own;
        bit   turn;
        bit   last;
        int   cnt;
        txn_t e;
        bit   mst, tout, oack;
        own  = -1;
        turn = 1'b0;
        last = 1'b1;
        cnt  = 0;
        e    = '0;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                chk_quiet("reset");
                own  = -1;
                turn = 1'b0;
                last = 1'b1;
            end else if (own < 0) begin
                chk_quiet(turn ? "turn" : "idle");
                if (turn) begin
                    turn = 1'b0;
                end else if (drv_stb[0] || drv_stb[1]) begin
                    own = (drv_stb[0] && drv_stb[1]) ? (last ? 0 : 1) : (drv_stb[0] ? 0 : 1);
                    if ((own == 0 && q0.size() == 0) || (own == 1 && q1.size() == 0)) begin
                        chk("sb_underflow", 64'd1, 64'd0);
                        e = '0;
                    end else begin
                        e = (own == 0) ? q0.pop_front() : q1.pop_front();
                    end
                    glog.push_back(own);
                    cnt = 0;
                end
            end else begin
                mst  = drv_stb[own];
                tout = (cnt == TO) && !s_ack;
                oack = s_ack || tout;
                chk("grant", 64'(grant), (own == 0) ? 64'd1 : 64'd2);
                chk("s_adr", 64'(s_adr), 64'(e.adr));
                chk("s_ctl", 64'({s_we, s_sel}), 64'({e.we, e.sel}));
                chk("s_do", 64'(s_do), 64'(e.di));
                chk("s_stb", 64'(s_stb), 64'(mst && !oack));
                chk("ack", 64'({m0_ack, m1_ack}), (own == 0) ? 64'({oack, 1'b0}) : 64'({1'b0, oack}));
                chk("err", 64'({m0_err, m1_err}), (own == 0) ? 64'({tout, 1'b0}) : 64'({1'b0, tout}));
                chk("m_do", 64'(m_do), s_ack ? 64'(s_di) : 64'd0);
                if (oack) begin
                    last = (own == 1);
                    own  = -1;
                    turn = 1'b1;
                end else begin
                    cnt++;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        logic [31:0] rd0, rd1;
        bit          ef0, ef1;
        bit          seen;
        int          n;

        for (int m = 0; m < 2; m++) begin
            drv_adr[m] = '0;
            drv_stb[m] = 1'b0;
            drv_we[m]  = 1'b0;
            drv_sel[m] = '0;
            drv_di[m]  = '0;
        end

        // Reset held with a pending m0 request and a stray slave ack.
        slave_en  = 1'b0;
        sys_rst_n = 1'b0;
        s_ack     = 1'b1;
        req(0, mk(26'h0000155, 1'b0, 4'h3, 32'h0));
        repeat (3) @(posedge sys_clk);
        #1;
        s_ack     = 1'b0;
        slave_en  = 1'b1;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("rel_idle_stb", 64'(s_stb), 64'd0);
        @(negedge sys_clk);
        chk("rel_stb", 64'(s_stb), 64'd1);
        chk("rel_adr", 64'(s_adr), 64'h155);
        wait_done(0, rd0, ef0);

        // Single read from m1 with a fixed 5-cycle slave latency.
        slave_delay = 5;
        slave_fix   = 1'b1;
        slave_data  = 32'hCAFEF00D;
        req(1, mk(26'h0001234, 1'b0, 4'hF, 32'h0));
        wait_done(1, rd1, ef1);
        chk("read_data", 64'(rd1), 64'hCAFEF00D);
        chk("read_err", 64'(ef1), 64'd0);
        slave_delay = -1;
        slave_fix   = 1'b0;

        // Write mux from m0.
        @(posedge sys_clk);
        #1;
        req(0, mk(26'h0000010, 1'b1, 4'hF, 32'h12345678));
        wait_done(0, rd0, ef0);
        chk("write_err", 64'(ef0), 64'd0);

        // Contention: m0 was served last, so m1 wins the first tie and grants alternate.
        glog.delete();
        fork
            run_master(0, 3, 0);
            run_master(1, 3, 0);
        join
        chk("cont_count", 64'(glog.size()), 64'd6);
        if (glog.size() > 0) chk("cont_first", 64'(glog[0]), 64'd1);
        for (int i = 1; i < glog.size(); i++) chk("cont_alt", 64'(glog[i] != glog[i-1]), 64'd1);

        // Watchdog: slave silent, m0 terminated with err on its TO+1-th busy cycle.
        slave_en = 1'b0;
        s_ack    = 1'b0;
        @(posedge sys_clk);
        #1;
        req(0, rnd_txn());
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge sys_clk);
            if (grant == 2'b01) n++;
            if (m0_ack) begin
                seen = 1'b1;
                chk("to_err", 64'(m0_err), 64'd1);
                chk("to_mdo", 64'(m_do), 64'd0);
            end
        end
        chk("to_seen", 64'(seen), 64'd1);
        chk("to_cycles", 64'(n), 64'(TO + 1));
        @(posedge sys_clk);
        #1;
        drv_stb[0] = 1'b0;
        @(posedge sys_clk);
        #1;
        s_ack = 1'b1;
        @(negedge sys_clk);
        chk("stray_ack", 64'({m0_ack, m1_ack, s_stb}), 64'd0);
        @(posedge sys_clk);
        #1;
        s_ack = 1'b0;

        // Reset asserted mid-transaction while m1 owns the port.
        req(1, rnd_txn());
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge sys_clk);
            if (grant == 2'b10) seen = 1'b1;
        end
        chk("busy1_reached", 64'(seen), 64'd1);
        @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b0;
        #1;
        chk("async_rst", 64'({s_stb, grant, m0_ack, m1_ack}), 64'd0);
        chk("async_rst_adr", 64'(s_adr), 64'd0);
        req(0, rnd_txn());
        req(1, rnd_txn());
        glog.delete();
        @(posedge sys_clk);
        #1;
        slave_en  = 1'b1;
        sys_rst_n = 1'b1;
        fork
            wait_done(0, rd0, ef0);
            wait_done(1, rd1, ef1);
        join
        chk("post_rst_count", 64'(glog.size()), 64'd2);
        if (glog.size() > 0) chk("post_rst_first", 64'(glog[0]), 64'd0);

        // Randomised traffic from both masters.
        fork
            run_master(0, 25, 3);
            run_master(1, 25, 3);
        join

        repeat (4) @(posedge sys_clk);
        chk("q_empty", 64'(q0.size() + q1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
